// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_pkg
// Description : Shared VGA timing defaults, derived-length helpers, the
//               pixel coordinate type and the per-pixel pipeline flag record
//               used by the binary frame reader.
// Revision    : 1.0  initial release
// ============================================================================
package vga_pkg;

    // Default 640x480@60 porch and sync lengths
    localparam int H_FRONT_DEFAULT = 16;
    localparam int H_SYNC_DEFAULT  = 96;
    localparam int H_BACK_DEFAULT  = 48;
    localparam int V_FRONT_DEFAULT = 10;
    localparam int V_SYNC_DEFAULT  = 2;
    localparam int V_BACK_DEFAULT  = 33;

    localparam int COORD_W = 13;
    typedef logic [COORD_W-1:0] coord_t;

    // Blanking length (front porch + sync + back porch)
    function automatic int blank_len(input int front, input int sync, input int back);
        return front + sync + back;
    endfunction

    // Total line/frame length including the active region
    function automatic int total_len(input int active, input int front,
                                     input int sync, input int back);
        return active + blank_len(front, sync, back);
    endfunction

    // Everything that travels alongside a pixel through the read pipeline
    typedef struct packed {
        logic       blank;
        logic       hs_n;
        logic       vs_n;
        logic       first_pix;
        logic       en;
        logic       inv;
        logic [2:0] bit_idx;
    } pix_flags_t;

    // Idle value: blanked, syncs inactive, no frame marker
    localparam pix_flags_t PIX_FLAGS_RESET = '{
        blank:     1'b1,
        hs_n:      1'b1,
        vs_n:      1'b1,
        first_pix: 1'b0,
        en:        1'b0,
        inv:       1'b0,
        bit_idx:   3'd0
    };

endpackage
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_gen
// Description : Free-running VGA raster counters. Produces blanking, active-low
//               syncs and active-area coordinates for the current counter
//               state (no pipeline delay).
// Ports       : clk, rst_n            - clock, async active-low reset
//               o_x, o_y              - active-area coordinates (wrap in blank)
//               o_blank               - outside the active area
//               o_hs_n, o_vs_n        - horizontal / vertical sync, active low
//               o_frame_boundary      - counters at (0,0)
//               o_first_pixel         - counters at first active pixel
// Revision    : 1.0  initial release
// ============================================================================
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int WIDTH   = 640,
    parameter int HEIGHT  = 480,
    parameter int H_FRONT = H_FRONT_DEFAULT,
    parameter int H_SYNC  = H_SYNC_DEFAULT,
    parameter int H_BACK  = H_BACK_DEFAULT,
    parameter int V_FRONT = V_FRONT_DEFAULT,
    parameter int V_SYNC  = V_SYNC_DEFAULT,
    parameter int V_BACK  = V_BACK_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [12:0] o_x,
    output logic [12:0] o_y,
    output logic        o_blank,
    output logic        o_hs_n,
    output logic        o_vs_n,
    output logic        o_frame_boundary,
    output logic        o_first_pixel
);

    localparam int H_BLANK = blank_len(H_FRONT, H_SYNC, H_BACK);
    localparam int V_BLANK = blank_len(V_FRONT, V_SYNC, V_BACK);
    localparam int H_TOTAL = total_len(WIDTH, H_FRONT, H_SYNC, H_BACK);
    localparam int V_TOTAL = total_len(HEIGHT, V_FRONT, V_SYNC, V_BACK);

    localparam coord_t H_LAST_C     = coord_t'(H_TOTAL - 1);
    localparam coord_t V_LAST_C     = coord_t'(V_TOTAL - 1);
    localparam coord_t H_BLANK_C    = coord_t'(H_BLANK);
    localparam coord_t V_BLANK_C    = coord_t'(V_BLANK);
    localparam coord_t H_FRONT_C    = coord_t'(H_FRONT);
    localparam coord_t V_FRONT_C    = coord_t'(V_FRONT);
    localparam coord_t H_SYNC_END_C = coord_t'(H_FRONT + H_SYNC);
    localparam coord_t V_SYNC_END_C = coord_t'(V_FRONT + V_SYNC);

    coord_t h_cont_q, h_cont_d;
    coord_t v_cont_q, v_cont_d;

    always_comb begin
        h_cont_d = h_cont_q + coord_t'(1);
        v_cont_d = v_cont_q;
        if (h_cont_q == H_LAST_C) begin
            h_cont_d = '0;
            v_cont_d = (v_cont_q == V_LAST_C) ? '0 : v_cont_q + coord_t'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cont_q <= '0;
            v_cont_q <= '0;
        end else begin
            h_cont_q <= h_cont_d;
            v_cont_q <= v_cont_d;
        end
    end

    assign o_blank = (h_cont_q < H_BLANK_C) || (v_cont_q < V_BLANK_C);

    // Sync pulse occupies counts FRONT+1 .. FRONT+SYNC inclusive
    assign o_hs_n = !((h_cont_q > H_FRONT_C) && (h_cont_q <= H_SYNC_END_C));
    assign o_vs_n = !((v_cont_q > V_FRONT_C) && (v_cont_q <= V_SYNC_END_C));

    // Coordinates wrap to large values during blanking; consumers gate on o_blank
    assign o_x = h_cont_q - H_BLANK_C;
    assign o_y = v_cont_q - V_BLANK_C;

    assign o_frame_boundary = (h_cont_q == '0) && (v_cont_q == '0);
    assign o_first_pixel    = (h_cont_q == H_BLANK_C) && (v_cont_q == V_BLANK_C);

endmodule
`default_nettype wire

// File: rtl/bw_frame_reader.sv
`default_nettype none
// ============================================================================
// Module      : bw_frame_reader
// Description : Scans a 1-bit-per-pixel packed frame (8 pixels per byte,
//               bit 0 = leftmost) and regenerates a full VGA stream.
//               Three-clock pipeline: counters -> address -> memory read ->
//               output registers. Syncs and blanking are delayed identically.
// Ports       : VGA_CLK, reset_n          - pixel clock, async active-low reset
//               enable, invert            - latched at each frame boundary
//               rdaddress / rd_q          - image memory port (1-clock read)
//               oVGA_R/G/B                - pixel colour
//               oVGA_HS, oVGA_VS          - syncs, active low
//               oVGA_SYNC_N, oVGA_BLANK_N - composite sync (0), active video
//               frame_start               - marks pixel (0,0) on the outputs
// Revision    : 1.0  initial release
// ============================================================================
module bw_frame_reader
    import vga_pkg::*;
#(
    parameter int WIDTH   = 640,
    parameter int HEIGHT  = 480,
    parameter int H_FRONT = H_FRONT_DEFAULT,
    parameter int H_SYNC  = H_SYNC_DEFAULT,
    parameter int H_BACK  = H_BACK_DEFAULT,
    parameter int V_FRONT = V_FRONT_DEFAULT,
    parameter int V_SYNC  = V_SYNC_DEFAULT,
    parameter int V_BACK  = V_BACK_DEFAULT
) (
    input  logic        VGA_CLK,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        invert,
    output logic [15:0] rdaddress,
    input  logic [7:0]  rd_q,
    output logic [7:0]  oVGA_R,
    output logic [7:0]  oVGA_G,
    output logic [7:0]  oVGA_B,
    output logic        oVGA_HS,
    output logic        oVGA_VS,
    output logic        oVGA_SYNC_N,
    output logic        oVGA_BLANK_N,
    output logic        frame_start
);

    localparam logic [15:0] WORDS_PER_LINE = 16'(WIDTH / 8);
    localparam logic [7:0]  RGB_WHITE      = 8'hFF;
    localparam logic [7:0]  RGB_BLACK      = 8'h00;
    localparam logic [7:0]  RGB_GREY       = 8'h80;

    // ------------------------------------------------------------------
    // Stage 0: raster counters
    // ------------------------------------------------------------------
    logic [12:0] w_x, w_y;
    logic        w_blank, w_hs_n, w_vs_n, w_frame_boundary, w_first_pixel;

    vga_timing_gen #(
        .WIDTH   (WIDTH),
        .HEIGHT  (HEIGHT),
        .H_FRONT (H_FRONT),
        .H_SYNC  (H_SYNC),
        .H_BACK  (H_BACK),
        .V_FRONT (V_FRONT),
        .V_SYNC  (V_SYNC),
        .V_BACK  (V_BACK)
    ) u_timing (
        .clk              (VGA_CLK),
        .rst_n            (reset_n),
        .o_x              (w_x),
        .o_y              (w_y),
        .o_blank          (w_blank),
        .o_hs_n           (w_hs_n),
        .o_vs_n           (w_vs_n),
        .o_frame_boundary (w_frame_boundary),
        .o_first_pixel    (w_first_pixel)
    );

    // Frame-level controls only change at the top-left of the raster
    logic enable_l_q, enable_l_d;
    logic inv_l_q, inv_l_d;

    always_comb begin
        enable_l_d = w_frame_boundary ? enable : enable_l_q;
        inv_l_d    = w_frame_boundary ? invert : inv_l_q;
    end

    // ------------------------------------------------------------------
    // Stage 1: address generation
    // ------------------------------------------------------------------
    logic [15:0] w_line_base;
    logic [15:0] rdaddress_q, rdaddress_d;
    pix_flags_t  s1_q, s1_d;

    always_comb begin
        w_line_base = {3'b000, w_y} * WORDS_PER_LINE;
        rdaddress_d = w_blank ? 16'd0 : (w_line_base + {6'b000000, w_x[12:3]});

        // The latched controls ride with each pixel so the last pixels of a
        // frame, still in flight when the next frame latches, keep their
        // own frame's settings.
        s1_d           = PIX_FLAGS_RESET;
        s1_d.blank     = w_blank;
        s1_d.hs_n      = w_hs_n;
        s1_d.vs_n      = w_vs_n;
        s1_d.first_pix = w_first_pixel;
        s1_d.en        = enable_l_q;
        s1_d.inv       = inv_l_q;
        s1_d.bit_idx   = w_x[2:0];
    end

    // ------------------------------------------------------------------
    // Stage 2: memory samples rdaddress; flags wait alongside
    // ------------------------------------------------------------------
    pix_flags_t s2_q, s2_d;

    always_comb begin
        s2_d = s1_q;
    end

    // ------------------------------------------------------------------
    // Stage 3: output registers
    // ------------------------------------------------------------------
    logic       w_pix;
    logic [7:0] rgb_q, rgb_d;
    logic       hs_q, hs_d;
    logic       vs_q, vs_d;
    logic       blank_n_q, blank_n_d;
    logic       frame_start_q, frame_start_d;

    always_comb begin
        // A set bit is a dark pixel
        w_pix = rd_q[s2_q.bit_idx] ^ s2_q.inv;

        rgb_d = RGB_BLACK;
        if (!s2_q.blank) begin
            if (!s2_q.en) begin
                rgb_d = RGB_GREY;
            end else begin
                rgb_d = w_pix ? RGB_BLACK : RGB_WHITE;
            end
        end

        hs_d          = s2_q.hs_n;
        vs_d          = s2_q.vs_n;
        blank_n_d     = !s2_q.blank;
        frame_start_d = s2_q.first_pix;
    end

    always_ff @(posedge VGA_CLK or negedge reset_n) begin
        if (!reset_n) begin
            enable_l_q    <= 1'b0;
            inv_l_q       <= 1'b0;
            rdaddress_q   <= 16'd0;
            s1_q          <= PIX_FLAGS_RESET;
            s2_q          <= PIX_FLAGS_RESET;
            rgb_q         <= RGB_BLACK;
            hs_q          <= 1'b1;
            vs_q          <= 1'b1;
            blank_n_q     <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            enable_l_q    <= enable_l_d;
            inv_l_q       <= inv_l_d;
            rdaddress_q   <= rdaddress_d;
            s1_q          <= s1_d;
            s2_q          <= s2_d;
            rgb_q         <= rgb_d;
            hs_q          <= hs_d;
            vs_q          <= vs_d;
            blank_n_q     <= blank_n_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign rdaddress    = rdaddress_q;
    assign oVGA_R       = rgb_q;
    assign oVGA_G       = rgb_q;
    assign oVGA_B       = rgb_q;
    assign oVGA_HS      = hs_q;
    assign oVGA_VS      = vs_q;
    assign oVGA_SYNC_N  = 1'b0;
    assign oVGA_BLANK_N = blank_n_q;
    assign frame_start  = frame_start_q;

endmodule
`default_nettype wire
